muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Execute-stage controller that sequences an iterative shift-add multiplier and shift-subtract divider for the RV32M instructions.
- Accepts one operation from the pipeline and holds the pipeline with `stall_req` while it iterates.
- Presents one result for one cycle, then returns to idle.
- Sits beside the main ALU. The decoder routes funct7=0000001 R-type ops here instead of to the ALU.

Parameters:
- XLEN, 32, operand/result width.
- EARLY_OUT, 1, enables single-cycle shortcut for divide-by-zero and signed-overflow cases.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch request; sampled only in IDLE
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value
- rd_in  in  5  destination register tag
- flush  in  1  abort current operation
- busy  out  1  state != IDLE
- stall_req  out  1  freeze upstream pipeline stages
- result_valid  out  1  one-cycle result strobe
- result  out  XLEN  final value
- rd_out  out  5  tag captured at accept

Behaviour:
- **Reset (rst_n=0, async):** state=IDLE; busy, stall_req, result_valid = 0; result and rd_out = 0; internal accumulator, remainder and counter cleared. Reset mid-operation discards the operation with no result.
- **FSM states:** IDLE, CALC, DONE.
- **IDLE → CALC:** on start=1 and flush=0 (accept cycle N).
  - Latch funct3 and rd_in.
  - Latch operand magnitudes and sign flags:
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - Others: unsigned.
  - Counter = XLEN.
- **CALC:** one iteration per cycle, counter decrements.
  - Multiply: 2*XLEN-bit product register, shift-add on LSB of multiplier.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - CALC → DONE when counter reaches 1. Cycles N+1..N+XLEN are CALC.
- **DONE (cycle N+XLEN+1):** result_valid=1 for exactly one cycle, then → IDLE.
  - result sign-corrected:
    - Product negated if signs differ (MULHSU uses op_a sign only).
    - Quotient negated if dividend and divisor signs differ.
    - Remainder takes the dividend's sign.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
  - DIV/DIVU return quotient; REM/REMU return remainder.
- **Early-out (EARLY_OUT=1), at accept:** IDLE → DONE directly; result_valid at N+1.
  - Divisor = 0:
    - DIV/DIVU quotient = all ones.
    - REM/REMU = op_a.
  - DIV/REM with op_a = 0x80000000 and op_b = 0xFFFFFFFF:
    - DIV quotient = 0x80000000.
    - REM = 0.
  - With EARLY_OUT=0 the iterative datapath produces the same RISC-V-defined values.
- **stall_req:** combinational.
  - High when (state==IDLE and start and !flush) or state==CALC.
  - Low in DONE, so the pipeline advances the instruction while result_valid writes back.
- **result and rd_out:** registered, updated only on entry to DONE; they hold their value afterward.
- **start while busy:** ignored. The pipeline is stalled, so the same instruction is not re-presented until DONE releases the stall. The instruction must not be re-launched: the decoder drops start for the instruction once result_valid is seen.
- **flush:**
  - Any state except IDLE → IDLE next cycle, no result_valid, stall_req drops in that same cycle.
  - flush and start together in IDLE: no accept.
  - flush in DONE: result_valid is suppressed.
- **Widths:** counter is $clog2(XLEN)+1 bits. Negation is two's complement within XLEN (or 2*XLEN for product).

Decomposition:
- **Shared package (rv32_pkg):**
  - funct3 constants for M-extension ops.
  - FUNCT7_MULDIV = 7'b0000001.
  - Enum for sequencer states.
  - XLEN default.
- **Sub-module muldiv_datapath:** product/remainder shift registers and add/sub unit, controlled by load/step/op signals from the FSM in muldiv_sequencer.

Test Plan:
- **MUL, signed high:** MUL op_a=7, op_b=6, start at cycle 0 → stall_req high cycles 0..32; result_valid at cycle 33, result=42; MULH op_a=0xFFFFFFFF (-1), op_b=2 → result=0xFFFFFFFF.
- **DIV/REM signed:** DIV op_a=-20, op_b=3 → quotient 0xFFFFFFFA (-6); REM same operands → 0xFFFFFFFE (-2); DIVU 100/7 → 14; REMU → 2.
- **Divide by zero and overflow:** DIVU 0x1234/0 → result_valid at cycle 1, 0xFFFFFFFF; REM 0x1234/0 → 0x1234; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- **Mid-operation aborts:** flush at cycle 10 of a DIV → idle at cycle 11, no result_valid, busy=0; rst_n pulled low at cycle 15 of a MULHU → all outputs 0 immediately.
- **Back-to-back and tags:** start held high across an operation, rd_in=5 then rd_in=9 → exactly one accept per IDLE; rd_out=5 then 9; no result_valid overlap; MULHSU op_a=-1, op_b=0xFFFFFFFF → 0xFFFFFFFF.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32M constants and sequencer state type
package rv32_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide iteration registers
module muldiv_datapath #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   load_a,
   input  logic [XLEN-1:0]   load_b,
   output logic [2*XLEN-1:0] step_val
);

   // acc holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opnd;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     diff;

   // value acc takes after one iteration; the top bit of diff is the borrow of the trial subtract
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      rem_sh  = acc[2*XLEN-1:XLEN-1];
      diff    = rem_sh - {1'b0, opnd};
      if (is_div) begin
         if (diff[XLEN]) begin
            step_val = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end else begin
            step_val = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end
      end else begin
         step_val = {mul_sum, acc[XLEN-1:1]};
      end
   end

   // load operand magnitudes at accept, then advance one iteration per step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         opnd <= '0;
      end else if (load) begin
         acc  <= {{XLEN{1'b0}}, load_a};
         opnd <= load_b;
      end else if (step) begin
         acc  <= step_val;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M execute-stage multiply/divide sequencer
module muldiv_sequencer
   import rv32_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int EARLY_OUT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            busy,
   output logic            stall_req,
   output logic            result_valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam int CW = $clog2(XLEN) + 1;

   seq_state_t state, state_next;

   logic            accept, finish, step, early;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic            neg_a_q, neg_b_q, bzero_q;
   logic [CW-1:0]   cnt;

   logic            signed_a, signed_b, neg_a, neg_b, b_zero, ovf;
   logic [XLEN-1:0] mag_a, mag_b, early_val, final_val, quo, rem;
   logic [2*XLEN-1:0] step_val, prod;

   muldiv_datapath #(.XLEN(XLEN)) u_datapath (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .step     (step),
      .is_div   (f3_q[2]),
      .load_a   (mag_a),
      .load_b   (mag_b),
      .step_val (step_val)
   );

   // operand signedness, magnitudes and the two RISC-V special divide cases
   always_comb begin
      signed_a  = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
      signed_b  = signed_a && (funct3 != F3_MULHSU);
      neg_a     = signed_a && op_a[XLEN-1];
      neg_b     = signed_b && op_b[XLEN-1];
      mag_a     = neg_a ? -op_a : op_a;
      mag_b     = neg_b ? -op_b : op_b;
      b_zero    = (op_b == '0);
      ovf       = signed_b && funct3[2] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      early     = (EARLY_OUT != 0) && funct3[2] && (b_zero || ovf);
      if (b_zero) begin
         early_val = funct3[1] ? op_a : '1;
      end else begin
         early_val = funct3[1] ? '0 : op_a;
      end
   end

   // sign-correct the final iteration; a zero divisor keeps the all-ones quotient
   always_comb begin
      prod = (neg_a_q ^ neg_b_q) ? -step_val : step_val;
      quo  = ((neg_a_q ^ neg_b_q) && !bzero_q) ? -step_val[XLEN-1:0] : step_val[XLEN-1:0];
      rem  = neg_a_q ? -step_val[2*XLEN-1:XLEN] : step_val[2*XLEN-1:XLEN];
      if (f3_q[2]) begin
         final_val = f3_q[1] ? rem : quo;
      end else if (f3_q == F3_MUL) begin
         final_val = prod[XLEN-1:0];
      end else begin
         final_val = prod[2*XLEN-1:XLEN];
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next state and per-cycle control; flush wins over every transition
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !flush) begin
               accept     = 1'b1;
               state_next = early ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (flush) begin
               state_next = ST_IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CW'(1)) begin
                  finish     = 1'b1;
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // stall drops in DONE so the instruction advances while its result writes back
   always_comb begin
      busy         = (state != ST_IDLE);
      stall_req    = !flush && (((state == ST_IDLE) && start) || (state == ST_CALC));
      result_valid = (state == ST_DONE) && !flush;
   end

   // operation context latched at accept, iteration counter, registered result and tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f3_q    <= '0;
         rd_q    <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         bzero_q <= 1'b0;
         cnt     <= '0;
         result  <= '0;
         rd_out  <= '0;
      end else begin
         if (accept) begin
            f3_q    <= funct3;
            rd_q    <= rd_in;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            bzero_q <= b_zero;
            cnt     <= CW'(XLEN);
         end else if (step) begin
            cnt     <= cnt - CW'(1);
         end
         if (accept && early) begin
            result <= early_val;
            rd_out <= rd_in;
         end else if (finish) begin
            result <= final_val;
            rd_out <= rd_q;
         end
      end
   end

endmodule
